busca_instrucao: RTL and testbench

BUSCA_INSTRUCAO -- requirements
Module: busca_instrucao

---
 rtl/busca_instrucao.sv | 92 +++++++++
 tb/tb_busca_instrucao.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/busca_instrucao.sv
// rtl/busca_instrucao.sv - instruction fetch unit: PC, IR and BUSCA/ESPERA/DECODIFICA fetch FSM
module busca_instrucao #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            EscCP,
  input  logic            EscCondCP,
  input  logic [1:0]      FonteCP,
  input  logic            EscIR,
  input  logic [PC_W-1:0] ula_result,
  input  logic            ula_zero,
  input  logic [15:0]     mem_data,
  input  logic            mem_ack,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  output logic [3:0]      opcode,
  output logic [3:0]      rd,
  output logic [3:0]      rs,
  output logic [3:0]      imm,
  output logic [PC_W-1:0] pc,
  output logic            instr_valid
);

  localparam logic [1:0] BUSCA      = 2'd0;
  localparam logic [1:0] ESPERA     = 2'd1;
  localparam logic [1:0] DECODIFICA = 2'd2;

  logic [1:0]       state;
  logic             started;
  logic [15:0]      ir;
  logic             pc_we;
  logic [PC_W-1:0]  pc_next;
  logic [PC_W+7:0]  ir_ext;

  assign ir_ext = {{PC_W{1'b0}}, ir[7:0]};
  assign pc_we  = (state == DECODIFICA) && (EscCP || (EscCondCP && ula_zero));

  always_comb begin
    pc_next = pc;
    case (FonteCP)
      2'b00:   pc_next = pc + PC_W'(1);
      2'b01:   pc_next = ula_result;
      2'b10:   pc_next = ir_ext[PC_W-1:0];
      default: pc_next = pc;
    endcase
  end

  // started holds BUSCA idle for the first edge after reset so mem_req stays low until then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BUSCA;
      started     <= 1'b0;
      pc          <= PC_W'(RESET_PC);
      ir          <= 16'h0000;
      instr_valid <= 1'b0;
    end else begin
      started <= 1'b1;
      if (pc_we)
        pc <= pc_next;
      case (state)
        BUSCA: begin
          if (started)
            state <= ESPERA;
        end
        ESPERA: begin
          if (mem_ack) begin
            ir          <= mem_data;
            instr_valid <= 1'b1;
            state       <= DECODIFICA;
          end
        end
        DECODIFICA: begin
          if (EscIR) begin
            instr_valid <= 1'b0;
            state       <= BUSCA;
          end
        end
        default: state <= BUSCA;
      endcase
    end
  end

  assign mem_req  = started && ((state == BUSCA) || (state == ESPERA));
  assign mem_addr = pc;
  assign opcode   = ir[15:12];
  assign rd       = ir[11:8];
  assign rs       = ir[7:4];
  assign imm      = ir[3:0];

endmodule

// File: tb/tb_busca_instrucao.sv
// tb/tb_busca_instrucao.sv - directed self-checking bench for busca_instrucao
module tb_busca_instrucao;

  logic        clk;
  logic        rst_n;
  logic        EscCP;
  logic        EscCondCP;
  logic [1:0]  FonteCP;
  logic        EscIR;
  logic [7:0]  ula_result;
  logic        ula_zero;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [3:0]  opcode;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  imm;
  logic [7:0]  pc;
  logic        instr_valid;

  int checks;
  int failures;

  busca_instrucao #(.PC_W(8), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .EscCP(EscCP), .EscCondCP(EscCondCP),
    .FonteCP(FonteCP), .EscIR(EscIR), .ula_result(ula_result), .ula_zero(ula_zero),
    .mem_data(mem_data), .mem_ack(mem_ack), .mem_req(mem_req), .mem_addr(mem_addr),
    .opcode(opcode), .rd(rd), .rs(rs), .imm(imm), .pc(pc), .instr_valid(instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One decode-cycle control word, applied for exactly one edge
  task automatic decode_op(input logic e, input logic c, input logic [1:0] f,
                           input logic i, input logic [7:0] u, input logic z);
    EscCP = e; EscCondCP = c; FonteCP = f; EscIR = i; ula_result = u; ula_zero = z;
    @(posedge clk); #1;
    EscCP = 0; EscCondCP = 0; FonteCP = 2'b00; EscIR = 0; ula_result = 8'h00; ula_zero = 0;
  endtask

  // Called just after the edge that entered BUSCA; returns just after entering DECODIFICA
  task automatic fetch(input logic [15:0] d, input int stall);
    @(posedge clk); #1;
    repeat (stall) begin @(posedge clk); #1; end
    mem_data = d; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL rst_pc got=%0h exp=00", pc); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%0b exp=0", mem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b exp=0", instr_valid); end
    checks++; if ({opcode, rd, rs, imm} !== 16'h0000) begin failures++; $display("FAIL rst_ir got=%0h exp=0000", {opcode, rd, rs, imm}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL pending_mem_req got=%0b exp=0", mem_req); end
  endtask

  task automatic test_first_fetch;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL busca_req got=%0b exp=1", mem_req); end
    checks++; if (mem_addr !== 8'h00) begin failures++; $display("FAIL busca_addr got=%0h exp=00", mem_addr); end
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL espera_req got=%0b exp=1", mem_req); end
    mem_data = 16'h3A5C; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL decod_req got=%0b exp=0", mem_req); end
    checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL decod_valid got=%0b exp=1", instr_valid); end
    checks++; if ({opcode, rd, rs, imm} !== 16'h3A5C) begin failures++; $display("FAIL decod_fields got=%0h exp=3a5c", {opcode, rd, rs, imm}); end
  endtask

  task automatic test_pc_wrap;
    decode_op(1, 0, 2'b01, 0, 8'hFF, 0);
    checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL load_ff got=%0h exp=ff", pc); end
    decode_op(1, 0, 2'b00, 1, 8'h00, 0);
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL wrap_pc got=%0h exp=00", pc); end
    checks++; if (mem_addr !== 8'h00 || mem_req !== 1'b1) begin failures++; $display("FAIL wrap_fetch got=%0h/%0b exp=00/1", mem_addr, mem_req); end
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL escir_clear got=%0b exp=0", instr_valid); end
    fetch(16'h5000, 0);
  endtask

  task automatic test_cond_branch;
    decode_op(0, 1, 2'b01, 0, 8'h40, 0);
    checks++; if (pc !== 8'h00) begin failures++; $display("FAIL cond_nz got=%0h exp=00", pc); end
    decode_op(0, 1, 2'b01, 0, 8'h40, 1);
    checks++; if (pc !== 8'h40) begin failures++; $display("FAIL cond_z got=%0h exp=40", pc); end
    decode_op(1, 0, 2'b11, 0, 8'h77, 0);
    checks++; if (pc !== 8'h40) begin failures++; $display("FAIL hold_11 got=%0h exp=40", pc); end
  endtask

  task automatic test_ir_target;
    decode_op(0, 0, 2'b00, 1, 8'h00, 0);
    checks++; if (mem_addr !== 8'h40) begin failures++; $display("FAIL refetch_addr got=%0h exp=40", mem_addr); end
    fetch(16'hB012, 0);
    checks++; if (opcode !== 4'hB || imm !== 4'h2) begin failures++; $display("FAIL ir_b012 got=%0h/%0h exp=b/2", opcode, imm); end
    decode_op(1, 0, 2'b10, 0, 8'h00, 0);
    checks++; if (pc !== 8'h12) begin failures++; $display("FAIL ir_target got=%0h exp=12", pc); end
    decode_op(0, 0, 2'b00, 1, 8'h00, 0);
    checks++; if (mem_addr !== 8'h12 || mem_req !== 1'b1) begin failures++; $display("FAIL ir_fetch got=%0h/%0b exp=12/1", mem_addr, mem_req); end
  endtask

  task automatic test_stall;
    @(posedge clk); #1;
    EscCP = 1; FonteCP = 2'b00; EscIR = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'h12 || pc !== 8'h12) begin
        failures++; $display("FAIL stall_%0d got=%0b/%0h/%0h exp=1/12/12", k, mem_req, mem_addr, pc);
      end
    end
    EscCP = 0; EscIR = 0;
    mem_data = 16'hC3D4; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++; if (instr_valid !== 1'b1 || opcode !== 4'hC || pc !== 8'h12) begin failures++; $display("FAIL stall_done got=%0b/%0h/%0h exp=1/c/12", instr_valid, opcode, pc); end
    mem_data = 16'hFFFF; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++; if ({opcode, rd, rs, imm} !== 16'hC3D4) begin failures++; $display("FAIL ack_ignored got=%0h exp=c3d4", {opcode, rd, rs, imm}); end
  endtask

  task automatic test_back_to_back;
    EscCP = 1; FonteCP = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      checks++; if (pc !== 8'(8'h12 + k)) begin failures++; $display("FAIL inc_%0d got=%0h exp=%0h", k, pc, 8'(8'h12 + k)); end
    end
    EscCP = 0;
  endtask

  task automatic test_reset_mid_fetch;
    decode_op(0, 0, 2'b00, 1, 8'h00, 0);
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h15) begin failures++; $display("FAIL pre_rst got=%0b/%0h exp=1/15", mem_req, mem_addr); end
    mem_data = 16'hFFFF; mem_ack = 1'b1; rst_n = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || pc !== 8'h00) begin failures++; $display("FAIL async_rst got=%0b/%0h exp=0/00", mem_req, pc); end
    checks++; if ({opcode, rd, rs, imm} !== 16'h0000 || instr_valid !== 1'b0) begin failures++; $display("FAIL async_ir got=%0h/%0b exp=0000/0", {opcode, rd, rs, imm}, instr_valid); end
    @(posedge clk); #1;
    checks++; if ({opcode, rd, rs, imm} !== 16'h0000 || mem_req !== 1'b0) begin failures++; $display("FAIL ack_in_rst got=%0h/%0b exp=0000/0", {opcode, rd, rs, imm}, mem_req); end
    mem_ack = 1'b0; rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin failures++; $display("FAIL refetch_rst got=%0b/%0h exp=1/00", mem_req, mem_addr); end
    fetch(16'h7123, 0);
    checks++; if (opcode !== 4'h7 || imm !== 4'h3 || instr_valid !== 1'b1) begin failures++; $display("FAIL post_rst got=%0h/%0h/%0b exp=7/3/1", opcode, imm, instr_valid); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b0; EscCP = 0; EscCondCP = 0; FonteCP = 2'b00; EscIR = 0;
    ula_result = 8'h00; ula_zero = 0; mem_data = 16'h0000; mem_ack = 0;
    test_reset;
    test_first_fetch;
    test_pc_wrap;
    test_cond_branch;
    test_ir_target;
    test_stall;
    test_back_to_back;
    test_reset_mid_fetch;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
